// File: rtl/data_io_xfer.sv
// Download receiver: oversamples the io controller SPI link, decodes file-transfer
// commands and packs payload bytes into a req/ack write port with byte enables.
module data_io_xfer #(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 8,
   parameter int unsigned START_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              ss,
   input  logic              sdi,
   output logic              downloading,
   output logic [7:0]        index,
   output logic [AW-1:0]     size,
   output logic              wr,
   input  logic              wr_ack,
   output logic [AW-1:0]     a,
   output logic [DW-1:0]     d,
   output logic [DW/8-1:0]   be,
   output logic              overrun
);

   localparam logic [7:0] CMD_FILE_TX     = 8'h53;
   localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
   localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

   typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

   state_t            state;
   logic [2:0]        sck_m;
   logic [1:0]        ss_m;
   logic [1:0]        sdi_m;
   logic [3:0]        cnt;
   logic [6:0]        sr;
   logic [7:0]        cmd;
   logic              lane;
   logic [7:0]        lo_byte;

   logic              sample;
   logic [7:0]        pbyte;
   logic              byte_done;
   logic              start_cmd;
   logic              end_cmd;
   logic              accept;
   logic              word_done;
   logic              partial;
   logic [DW-1:0]     word_full;
   logic [DW-1:0]     word_part;
   logic [DW/8-1:0]   be_part;

   always_comb begin
      sample    = sck_m[1] & ~sck_m[2] & ~ss_m[1];
      pbyte     = {sr, sdi_m[1]};
      byte_done = sample && (cnt == 4'd15);
      start_cmd = byte_done && (cmd == CMD_FILE_TX) && pbyte[0];
      end_cmd   = byte_done && (cmd == CMD_FILE_TX) && !pbyte[0];
      accept    = byte_done && (cmd == CMD_FILE_TX_DAT) && downloading && (state != FLUSH);
      partial   = (DW == 16) && lane;
      word_done = accept && ((DW == 8) || lane);
      // For DW=8 the upper-lane write overlays lane 0 with the current byte.
      word_full            = '0;
      word_full[7:0]       = (DW == 16) ? lo_byte : pbyte;
      word_full[DW-1 -: 8] = pbyte;
      word_part            = '0;
      word_part[7:0]       = lo_byte;
      be_part              = '0;
      be_part[0]           = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_m       <= '0;
         ss_m        <= '0;
         sdi_m       <= '0;
         cnt         <= '0;
         sr          <= '0;
         cmd         <= '0;
         lane        <= 1'b0;
         lo_byte     <= '0;
         state       <= IDLE;
         downloading <= 1'b0;
         index       <= '0;
         size        <= '0;
         wr          <= 1'b0;
         a           <= AW'(START_ADDR);
         d           <= '0;
         be          <= '0;
         overrun     <= 1'b0;
      end else begin
         sck_m <= {sck_m[1:0], sck};
         ss_m  <= {ss_m[0], ss};
         sdi_m <= {sdi_m[0], sdi};

         if (ss_m[1]) begin
            cnt <= '0;
            sr  <= '0;
         end else if (sample) begin
            sr <= pbyte[6:0];
            if (cnt == 4'd7)
               cmd <= pbyte;
            cnt <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
         end

         if (byte_done && (cmd == CMD_FILE_INDEX) && !downloading)
            index <= pbyte;

         if (accept) begin
            size <= size + AW'(1);
            if (DW == 16) begin
               lane <= ~lane;
               if (!lane)
                  lo_byte <= pbyte;
            end
         end

         if (start_cmd) begin
            a           <= AW'(START_ADDR);
            size        <= '0;
            lane        <= 1'b0;
            overrun     <= 1'b0;
            downloading <= 1'b1;
            wr          <= 1'b0;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (word_done) begin
                     wr    <= 1'b1;
                     d     <= word_full;
                     be    <= '1;
                     state <= REQ;
                  end else if (end_cmd && downloading) begin
                     if (partial) begin
                        wr    <= 1'b1;
                        d     <= word_part;
                        be    <= be_part;
                        lane  <= 1'b0;
                        state <= FLUSH;
                     end else begin
                        downloading <= 1'b0;
                     end
                  end
               end
               REQ: begin
                  if (wr_ack) begin
                     a     <= a + AW'(1);
                     wr    <= 1'b0;
                     state <= IDLE;
                  end
                  // A word landing on the ack cycle replaces the finished request.
                  if (word_done) begin
                     if (wr_ack) begin
                        wr    <= 1'b1;
                        d     <= word_full;
                        be    <= '1;
                        state <= REQ;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
                  if (end_cmd) begin
                     if (!wr_ack) begin
                        state <= FLUSH;
                     end else if (partial) begin
                        wr    <= 1'b1;
                        d     <= word_part;
                        be    <= be_part;
                        lane  <= 1'b0;
                        state <= FLUSH;
                     end else begin
                        downloading <= 1'b0;
                        state       <= IDLE;
                     end
                  end
               end
               FLUSH: begin
                  if (!wr || wr_ack) begin
                     if (wr)
                        a <= a + AW'(1);
                     if (partial) begin
                        wr   <= 1'b1;
                        d    <= word_part;
                        be   <= be_part;
                        lane <= 1'b0;
                     end else begin
                        wr          <= 1'b0;
                        downloading <= 1'b0;
                        state       <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
